// File: rtl/wfi_wake_injector.sv
// wfi_wake_injector: stimulus block that wakes a core out of WFI.
//
// Each WFI rising edge (with enable high) arms a pseudo-random delay taken
// from a free-running 16-bit Galois LFSR. The block then raises one of the
// machine interrupt lines (ext/timer/software) and holds it until the core
// leaves WFI and software acknowledges, or until a bounded hold expires.
// Cores that never leave WFI are flagged through the sticky timeout_err.
//
// Optional build macro: WFI_INJ_LATENCY_EN
//   When defined, adds output max_wake_latency[15:0], the largest number of
//   cycles seen between interrupt assertion and the core dropping wfi.
//   When undefined, that port, its counter and its comparator are absent.

module wfi_wake_injector #(
    parameter int unsigned MIN_DELAY   = 4,        // minimum rise-to-assert delay
    parameter logic [7:0]  DELAY_MASK  = 8'h3F,    // mask on LFSR for extra delay
    parameter int unsigned HOLD_CYCLES = 16,       // max hold after wake with no ack
    parameter int unsigned TIMEOUT     = 1000,     // assert cycles before timeout_err
    parameter logic [15:0] SEED        = 16'hACE1  // LFSR reset value, nonzero
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        wfi,
    input  logic [1:0]  line_sel,
    input  logic        int_ack,
    output logic        ext_int,
    output logic        timer_int,
    output logic        sw_int,
    output logic        busy,
    output logic [31:0] wake_count,
    output logic [15:0] early_wake_count,
    output logic        timeout_err
`ifdef WFI_INJ_LATENCY_EN
    ,
    output logic [15:0] max_wake_latency
`endif
);

    // Counter widths sized from the parameters so comparisons stay exact.
    localparam int DLY_W  = $clog2(MIN_DELAY + 256) + 1;
    localparam int TCNT_W = $clog2(TIMEOUT + 1);
    localparam int HCNT_W = $clog2(HOLD_CYCLES + 1);

    // Galois feedback mask for x^16 + x^14 + x^13 + x^11 (right-shifting form).
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,  // waiting for an armed WFI rise
        S_DELAY  = 2'd1,  // counting down the random delay
        S_ASSERT = 2'd2,  // line driven, waiting for the core to wake
        S_HOLD   = 2'd3   // line still driven, waiting for ack or hold expiry
    } state_e;

    state_e              state_q, state_d;
    logic [15:0]         lfsr_q, lfsr_d;
    logic                wfi_q, wfi_d;
    logic [DLY_W-1:0]    dly_q, dly_d;
    logic [1:0]          sel_q, sel_d;
    logic [TCNT_W-1:0]   tcnt_q, tcnt_d;
    logic [HCNT_W-1:0]   hcnt_q, hcnt_d;
    logic                ack_pend_q, ack_pend_d;
    logic [2:0]          line_q, line_d;       // {sw, timer, ext}
    logic                busy_q, busy_d;
    logic [31:0]         wake_count_q, wake_count_d;
    logic [15:0]         early_q, early_d;
    logic                timeout_q, timeout_d;
`ifdef WFI_INJ_LATENCY_EN
    logic [15:0]         lat_q, lat_d;
    logic [15:0]         max_lat_q, max_lat_d;
    logic [15:0]         lat_now;
`endif

    logic                wfi_rise;
    logic [1:0]          rand_sel;
    logic [DLY_W-1:0]    dly_load;

    assign wfi_rise = wfi & ~wfi_q;

    // LFSR bits [9:8] folded onto 0..2 (value 3 wraps to ext).
    assign rand_sel = (lfsr_q[9:8] == 2'd3) ? 2'd0 : lfsr_q[9:8];

    // Delay loaded on arming: fixed floor plus the masked LFSR low byte.
    assign dly_load = DLY_W'(MIN_DELAY) + DLY_W'(lfsr_q[7:0] & DELAY_MASK);

    // Next-state, counter and registered-output computation.
    // NOTE: every variable written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d      = state_q;
        lfsr_d       = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
        wfi_d        = wfi;
        dly_d        = dly_q;
        sel_d        = sel_q;
        tcnt_d       = tcnt_q;
        hcnt_d       = hcnt_q;
        ack_pend_d   = ack_pend_q;
        wake_count_d = wake_count_q;
        early_d      = early_q;
        timeout_d    = timeout_q;
`ifdef WFI_INJ_LATENCY_EN
        lat_now      = (lat_q == 16'hFFFF) ? lat_q : lat_q + 16'd1;
        lat_d        = lat_q;
        max_lat_d    = max_lat_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (wfi_rise && enable) begin
                    state_d = S_DELAY;
                    dly_d   = dly_load;
                    sel_d   = (line_sel == 2'd3) ? rand_sel : line_sel;
                end
            end

            S_DELAY: begin
                dly_d = dly_q - DLY_W'(1);
                if (!wfi) begin
                    // Core woke on its own before we injected anything.
                    if (early_q != 16'hFFFF) begin
                        early_d = early_q + 16'd1;
                    end
                    state_d = S_IDLE;
                end else if (dly_q == DLY_W'(1)) begin
                    state_d = S_ASSERT;
                    tcnt_d  = '0;
`ifdef WFI_INJ_LATENCY_EN
                    lat_d   = '0;
`endif
                end
            end

            S_ASSERT: begin
                if (!wfi) begin
                    wake_count_d = wake_count_q + 32'd1;
                    tcnt_d       = '0;
                    hcnt_d       = '0;
                    // An ack coinciding with the wake is remembered and
                    // released on the first HOLD cycle.
                    ack_pend_d   = int_ack;
                    state_d      = S_HOLD;
`ifdef WFI_INJ_LATENCY_EN
                    if (lat_now > max_lat_q) begin
                        max_lat_d = lat_now;
                    end
`endif
                end else if (tcnt_q == TCNT_W'(TIMEOUT - 1)) begin
                    // Core never woke: flag it and fall into the bounded hold.
                    timeout_d  = 1'b1;
                    hcnt_d     = '0;
                    ack_pend_d = 1'b0;
                    state_d    = S_HOLD;
                end else begin
                    tcnt_d = tcnt_q + TCNT_W'(1);
`ifdef WFI_INJ_LATENCY_EN
                    lat_d  = lat_now;
`endif
                end
            end

            S_HOLD: begin
                if (int_ack || ack_pend_q || (hcnt_q == HCNT_W'(HOLD_CYCLES - 1))) begin
                    ack_pend_d = 1'b0;
                    state_d    = S_IDLE;
                end else begin
                    hcnt_d = hcnt_q + HCNT_W'(1);
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are registered from the next state so they change on the
        // same edge as the FSM; only the selected line can ever be high.
        line_d = 3'b000;
        if ((state_d == S_ASSERT) || (state_d == S_HOLD)) begin
            line_d = 3'b001 << sel_q;
        end
        busy_d = (state_d != S_IDLE);
    end

    // State, LFSR, counters and registered outputs.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            lfsr_q       <= SEED;
            wfi_q        <= 1'b0;
            dly_q        <= '0;
            sel_q        <= 2'd0;
            tcnt_q       <= '0;
            hcnt_q       <= '0;
            ack_pend_q   <= 1'b0;
            line_q       <= 3'b000;
            busy_q       <= 1'b0;
            wake_count_q <= 32'd0;
            early_q      <= 16'd0;
            timeout_q    <= 1'b0;
`ifdef WFI_INJ_LATENCY_EN
            lat_q        <= 16'd0;
            max_lat_q    <= 16'd0;
`endif
        end else begin
            state_q      <= state_d;
            lfsr_q       <= lfsr_d;
            wfi_q        <= wfi_d;
            dly_q        <= dly_d;
            sel_q        <= sel_d;
            tcnt_q       <= tcnt_d;
            hcnt_q       <= hcnt_d;
            ack_pend_q   <= ack_pend_d;
            line_q       <= line_d;
            busy_q       <= busy_d;
            wake_count_q <= wake_count_d;
            early_q      <= early_d;
            timeout_q    <= timeout_d;
`ifdef WFI_INJ_LATENCY_EN
            lat_q        <= lat_d;
            max_lat_q    <= max_lat_d;
`endif
        end
    end

    assign ext_int          = line_q[0];
    assign timer_int        = line_q[1];
    assign sw_int           = line_q[2];
    assign busy             = busy_q;
    assign wake_count       = wake_count_q;
    assign early_wake_count = early_q;
    assign timeout_err      = timeout_q;
`ifdef WFI_INJ_LATENCY_EN
    assign max_wake_latency = max_lat_q;
`endif

endmodule

// File: tb/tb_wfi_wake_injector.sv
// Self-checking bench for wfi_wake_injector: directed scenarios plus a
// randomized phase, all compared every cycle against an event-timestamp model.
// Honours the WFI_INJ_LATENCY_EN build macro for the optional latency output.

module tb_wfi_wake_injector;

    localparam int unsigned MIN_DELAY   = 4;
    localparam logic [7:0]  DELAY_MASK  = 8'h3F;
    localparam int unsigned HOLD_CYCLES = 16;
    localparam int unsigned TIMEOUT     = 1000;
    localparam logic [15:0] SEED        = 16'hACE1;

    logic        clock    = 1'b0;
    logic        reset_n  = 1'b0;
    logic        enable   = 1'b0;
    logic        wfi      = 1'b0;
    logic [1:0]  line_sel = 2'd0;
    logic        int_ack  = 1'b0;
    logic        ext_int, timer_int, sw_int, busy, timeout_err;
    logic [31:0] wake_count;
    logic [15:0] early_wake_count;
`ifdef WFI_INJ_LATENCY_EN
    logic [15:0] max_wake_latency;
`endif

    int vectors    = 0;
    int miscompares = 0;

    always #5 clock = ~clock;

    wfi_wake_injector #(
        .MIN_DELAY(MIN_DELAY), .DELAY_MASK(DELAY_MASK), .HOLD_CYCLES(HOLD_CYCLES),
        .TIMEOUT(TIMEOUT), .SEED(SEED)
    ) dut (
        .clock(clock), .reset_n(reset_n), .enable(enable), .wfi(wfi),
        .line_sel(line_sel), .int_ack(int_ack),
        .ext_int(ext_int), .timer_int(timer_int), .sw_int(sw_int), .busy(busy),
        .wake_count(wake_count), .early_wake_count(early_wake_count),
        .timeout_err(timeout_err)
`ifdef WFI_INJ_LATENCY_EN
        , .max_wake_latency(max_wake_latency)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model (event timestamps) ----------------
    bit [15:0]   m_lfsr;
    bit          m_prev_wfi;
    int          m_cyc;
    bit          m_pending;      // waiting for the scheduled assertion
    int          m_fire;         // cycle the line is scheduled to rise
    bit          m_line;         // a line is being driven
    bit          m_woken;        // core woke or timed out; line in bounded hold
    int          m_on;           // cycle the line rose
    int          m_hold_from;    // cycle the hold began
    bit          m_ack_pend;
    int          m_sel;
    int unsigned m_wake;
    int          m_early;
    bit          m_timeout;
    int          m_maxlat;

    function automatic bit [15:0] lfsr_next(input bit [15:0] v);
        bit [15:0] r;
        r = v >> 1;
        if (v[0]) r = r ^ 16'hB400;
        return r;
    endfunction

    task automatic model_reset();
        m_lfsr = SEED; m_prev_wfi = 0; m_cyc = 0; m_pending = 0; m_fire = 0;
        m_line = 0; m_woken = 0; m_on = 0; m_hold_from = 0; m_ack_pend = 0;
        m_sel = 0; m_wake = 0; m_early = 0; m_timeout = 0; m_maxlat = 0;
    endtask

    task automatic model_step();
        bit rise;
        int lat;
        m_cyc++;
        rise = wfi && !m_prev_wfi;
        if (m_pending) begin
            if (!wfi) begin
                if (m_early < 65535) m_early++;
                m_pending = 0;
            end else if (m_cyc == m_fire) begin
                m_pending = 0; m_line = 1; m_woken = 0; m_on = m_cyc;
            end
        end else if (m_line && !m_woken) begin
            if (!wfi) begin
                m_wake++;
                lat = m_cyc - m_on;
                if (lat > 65535) lat = 65535;
                if (lat > m_maxlat) m_maxlat = lat;
                m_woken = 1; m_hold_from = m_cyc; m_ack_pend = int_ack;
            end else if (m_cyc - m_on == int'(TIMEOUT)) begin
                m_timeout = 1; m_woken = 1; m_hold_from = m_cyc; m_ack_pend = 0;
            end
        end else if (m_line) begin
            if (int_ack || m_ack_pend || (m_cyc - m_hold_from == int'(HOLD_CYCLES))) begin
                m_line = 0; m_woken = 0; m_ack_pend = 0;
            end
        end else if (rise && enable) begin
            m_fire    = m_cyc + int'(MIN_DELAY) + int'(m_lfsr[7:0] & DELAY_MASK);
            m_pending = 1;
            m_sel     = (line_sel == 2'd3) ? int'(m_lfsr[9:8]) % 3 : int'(line_sel);
        end
        m_prev_wfi = wfi;
        m_lfsr     = lfsr_next(m_lfsr);
    endtask

    always @(posedge clock) begin
        if (reset_n) model_step();
    end

    // Compare every cycle on the falling edge, away from the active edge.
    always @(negedge clock) begin
        if (reset_n) begin
            check("cmp_ext_int",   ext_int,   m_line && (m_sel == 0));
            check("cmp_timer_int", timer_int, m_line && (m_sel == 1));
            check("cmp_sw_int",    sw_int,    m_line && (m_sel == 2));
            check("cmp_busy",      busy,      m_pending || m_line);
            check("cmp_wake_count", wake_count, m_wake);
            check("cmp_early_count", {16'd0, early_wake_count}, m_early);
            check("cmp_timeout_err", timeout_err, m_timeout);
`ifdef WFI_INJ_LATENCY_EN
            check("cmp_max_latency", {16'd0, max_wake_latency}, m_maxlat);
`endif
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(negedge clock);
    endtask

    task automatic pulse_reset(input int n);
        reset_n = 1'b0;
        model_reset();
        repeat (n) tick();
        reset_n = 1'b1;
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while (busy && k < 200) begin tick(); k++; end
        check(name, busy, 1'b0);
    endtask

    // Raises wfi and returns how many cycles after the sampled rise the
    // first interrupt line came up (-1 if none within the bound).
    task automatic rise_and_wait_line(output int delay);
        int k;
        wfi = 1'b1;
        k = 0;
        delay = -1;
        while (k < 200) begin
            tick(); k++;
            if (ext_int || timer_int || sw_int) begin delay = k - 1; break; end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int d, ts, tt, tf, sw_at_tt, found, any_line, seen;
        logic [2:0] lines;

        // ---- Test 1: reset holds everything quiet even with wfi/enable high
        model_reset();
        reset_n = 1'b0; wfi = 1'b1; enable = 1'b1;
        repeat (5) begin
            tick();
            check("t1_ints", {ext_int, timer_int, sw_int}, 3'b000);
            check("t1_busy", busy, 1'b0);
            check("t1_wake_count", wake_count, 32'd0);
            check("t1_timeout_err", timeout_err, 1'b0);
        end
        wfi = 1'b0;
        reset_n = 1'b1;
        repeat (3) tick();

        // ---- Test 2: timer line, zero extra delay, wake after 3, ack
        line_sel = 2'd1;
        found = 0;
        for (int i = 0; i < 4000 && found == 0; i++) begin
            if ((m_lfsr[7:0] & DELAY_MASK) == 8'd0) found = 1;
            else tick();
        end
        check("t2_zero_mask_window", found, 1);
        rise_and_wait_line(d);
        check("t2_delay", d, 4);
        check("t2_timer_up", timer_int, 1'b1);
        tick(); tick();
        wfi = 1'b0;
        tick();
        int_ack = 1'b1;
        check("t2_line_in_hold", timer_int, 1'b1);
        tick();
        int_ack = 1'b0;
        check("t2_released", timer_int, 1'b0);
        check("t2_wake_count", wake_count, 32'd1);
`ifdef WFI_INJ_LATENCY_EN
        check("t2_max_latency", {16'd0, max_wake_latency}, 32'd3);
`endif

        // ---- Test 3: early wake during the delay
        wait_idle("t3_idle_before");
        line_sel = 2'd0;
        any_line = 0;
        wfi = 1'b1;
        tick(); any_line |= int'(ext_int | timer_int | sw_int);
        tick(); any_line |= int'(ext_int | timer_int | sw_int);
        wfi = 1'b0;
        repeat (4) begin tick(); any_line |= int'(ext_int | timer_int | sw_int); end
        check("t3_no_line", any_line, 0);
        check("t3_early_count", {16'd0, early_wake_count}, 32'd1);
        check("t3_busy_back", busy, 1'b0);

        // ---- Test 4: core never wakes -> timeout, then bounded hold
        line_sel = 2'd2;
        ts = -1; tt = -1; tf = -1; sw_at_tt = 0;
        wfi = 1'b1;
        for (int i = 1; i <= 1200; i++) begin
            tick();
            if (ts < 0 && sw_int) ts = i;
            if (tt < 0 && timeout_err) begin tt = i; sw_at_tt = int'(sw_int); end
            if (ts >= 0 && tf < 0 && !sw_int) tf = i;
        end
        wfi = 1'b0;
        tick();
        check("t4_sw_seen", int'(ts >= 0), 1);
        check("t4_timeout_err", timeout_err, 1'b1);
        check("t4_timeout_gap", tt - ts, 1000);
        check("t4_line_high_at_timeout", sw_at_tt, 1);
        check("t4_hold_gap", tf - tt, 16);

        // ---- Test 5: random line selection over 50 episodes
        pulse_reset(3);
        line_sel = 2'd3;
        seen = 0;
        for (int ep = 0; ep < 50; ep++) begin
            wait_idle("t5_idle");
            rise_and_wait_line(d);
            lines = {sw_int, timer_int, ext_int};
            check("t5_delay_range", int'(d >= 4 && d <= 67), 1);
            check("t5_onehot", $countones(lines), 1);
            seen |= int'(lines);
            wfi = 1'b0;
            tick();
            int_ack = 1'b1;
            tick();
            int_ack = 1'b0;
        end
        wait_idle("t5_idle_end");
        check("t5_wake_count", wake_count, 32'd50);
        check("t5_all_lines_used", seen, 7);
`ifdef WFI_INJ_LATENCY_EN
        check("t5_max_latency", {16'd0, max_wake_latency}, 32'd1);
`endif

        // ---- Test 6: asynchronous reset while ext_int is held
        line_sel = 2'd0;
        rise_and_wait_line(d);
        check("t6_ext_up", ext_int, 1'b1);
        wfi = 1'b0;
        tick(); tick();
        check("t6_ext_in_hold", ext_int, 1'b1);
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        check("t6_ext_async_drop", ext_int, 1'b0);
        check("t6_busy_async", busy, 1'b0);
        check("t6_wake_async", wake_count, 32'd0);
        tick(); tick();
        reset_n = 1'b1;
        tick();
        check("t6_busy_after", busy, 1'b0);
        check("t6_wake_after", wake_count, 32'd0);
        check("t6_early_after", {16'd0, early_wake_count}, 32'd0);

        // ---- Randomized phase: every cycle compared against the model
        for (int i = 0; i < 3000; i++) begin
            enable  = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 15) == 0) line_sel = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 11) == 0) wfi = ~wfi;
            int_ack = ($urandom_range(0, 9) == 0);
            tick();
        end
        int_ack = 1'b0;
        wfi = 1'b0;
        repeat (40) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/wfi_wake_injector.md
Name: wfi_wake_injector

Overview:
- Testbench stimulus block upstream of the WFI checker; drives the core's interrupt lines (ext/timer/software) to wake it from WFI.
- Detects the WFI rising edge and waits a pseudo-random delay from an LFSR. Then asserts one selected interrupt line and holds it until the core wakes and software acknowledges.
- Also flags cores that never wake.
- Its interrupt outputs feed both the core and the checker's interrupt-pending inputs.

Parameters:
- MIN_DELAY, 4, minimum cycles from WFI rise to interrupt assertion
- DELAY_MASK, 8'h3F, AND-mask applied to LFSR to form extra delay (power-of-two-minus-one)
- HOLD_CYCLES, 16, max cycles interrupt stays high after wfi deasserts if no ack
- TIMEOUT, 1000, cycles in ASSERT with wfi still high before timeout_err
- SEED, 16'hACE1, LFSR reset value (must be nonzero)

Ports:
- clock  in  1  testbench clock
- reset_n  in  1  async active-low reset
- enable  in  1  arm injector; sampled in IDLE only
- wfi  in  1  core WFI status
- line_sel  in  2  0=ext, 1=timer, 2=software, 3=LFSR-random among 0..2
- int_ack  in  1  pulse from bench (tohost/mip clear observed); releases line
- ext_int  out  1  machine external interrupt drive
- timer_int  out  1  machine timer interrupt drive
- sw_int  out  1  machine software interrupt drive
- busy  out  1  FSM not in IDLE
- wake_count  out  32  completed injections (wfi fell while line asserted)
- early_wake_count  out  16  wfi fell during DELAY (no injection)
- timeout_err  out  1  sticky, core failed to wake

Behaviour:
- Async reset (reset_n low): state=IDLE, all int outputs 0, busy 0, counters 0, timeout_err 0, lfsr=SEED, wfi_q=0. Reset mid-operation drops any asserted line in the same instant.
- LFSR: 16-bit Galois, taps x^16+x^14+x^13+x^11, advances every cycle regardless of state.
- wfi_q registers wfi; rise = wfi & !wfi_q.
- IDLE: on rise & enable, load dly = MIN_DELAY + (lfsr[7:0] & DELAY_MASK). Latch sel = line_sel, or lfsr[9:8] mod 3 when line_sel=3. Go to DELAY. A rise with enable low is ignored.
- DELAY: dly decrements each cycle.
  - wfi low before dly reaches 0: early_wake_count++ (saturating), go to IDLE.
  - dly==1 and wfi high: go to ASSERT. The line rises exactly MIN_DELAY+mask-value cycles after the cycle the rise was sampled.
- ASSERT: selected output = 1, others 0; tcnt increments.
  - wfi low: wake_count++ (wraps), clear tcnt, go to HOLD.
  - tcnt reaches TIMEOUT with wfi high: set timeout_err (sticky until reset), go to HOLD (line stays high).
- HOLD: line stays high; hcnt increments. Deassert and go to IDLE on int_ack or hcnt==HOLD_CYCLES, whichever comes first.
  - int_ack in the same cycle wfi falls in ASSERT is honoured one cycle later in HOLD.
  - A wfi rise while in HOLD is ignored; re-arm only from IDLE.
- int_ack outside HOLD has no effect.
- Outputs are registered; at most one int output is high at any time.
- busy = (state != IDLE), registered.

Optional Feature:
- Macro: WFI_INJ_LATENCY_EN.
- Defined: adds output max_wake_latency[15:0] (reset 0) and a 16-bit saturating counter of cycles from line assertion to wfi fall. On each wake, max_wake_latency = max(old, latency). Latency is 1 when wfi falls the cycle after assertion.
- Undefined: port, counter and comparator absent; all other behaviour identical.

Test Plan:
- Test 1: reset_n=0 for 5 cycles with wfi=1, enable=1 -> all int outputs 0, busy 0, wake_count 0, timeout_err 0.
- Test 2: enable=1, line_sel=1, DELAY_MASK forced 0 (MIN_DELAY=4); raise wfi, drop it 3 cycles after timer_int rises, pulse int_ack next cycle.
  - timer_int rises 4 cycles after the rise is sampled; wake_count=1; timer_int falls the cycle after int_ack.
  - With WFI_INJ_LATENCY_EN: max_wake_latency=3.
- Test 3: line_sel=0; raise wfi, drop it 2 cycles later (during DELAY) -> no int output ever asserts, early_wake_count=1, busy returns 0.
- Test 4: line_sel=2; hold wfi high 1200 cycles -> sw_int asserts; timeout_err=1 at cycle TIMEOUT=1000 after assertion; sw_int deasserts HOLD_CYCLES=16 cycles later with no ack.
- Test 5: line_sel=3, 50 WFI episodes with wfi dropped on each assertion -> wake_count=50, each assertion one-hot, each chosen line in {ext,timer,sw}, every delay in [4,67].
- Test 6: assert reset_n low while ext_int high in HOLD -> ext_int 0 immediately (async); after release, state IDLE, counters 0.
